// File: rtl/instr_fetch_unit_if.sv
// Instruction-fetch bus bundle: memory request/response, decoded-instruction
// handoff to the processor and the branch/jump redirect path.
interface instr_fetch_unit_if;
  // Handshakes: mem_req is a one-cycle strobe with mem_addr valid alongside it,
  // answered by exactly one mem_rvalid pulse at least one cycle later; an
  // instruction moves to the processor on a clock edge where ins_valid and
  // ins_ready are both high; redirect is a single-cycle command.
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output mem_req, mem_addr, ins, ins_pc, ins_valid,
    input  mem_rdata, mem_rvalid, ins_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, ins, ins_pc, ins_valid,
    output mem_rdata, mem_rvalid, ins_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch PC owner with a PC-tagged prefetch FIFO and redirect-aware drop logic.
// Optional IFU_STATS_EN adds saturating fetch_count / drop_count outputs.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master bus,
  output logic [1:0]         state_o
`ifdef IFU_STATS_EN
  ,
  output logic [15:0]        fetch_count,
  output logic [15:0]        drop_count
`endif
);

  localparam int unsigned   PW      = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned   CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_t;

  state_t        state_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   addr_q;
  logic [31:0]   word_q [FIFO_DEPTH];
  logic [31:0]   pc_q   [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;

  logic empty, pop, push, issue, discard;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  // Redirect masks both pop and push: the flush wins over everything in that edge.
  always_comb begin
    empty   = (count_q == '0);
    pop     = bus.ins_ready && !empty && !bus.redirect;
    push    = (state_q == WAIT) && bus.mem_rvalid && !bus.redirect;
    discard = bus.mem_rvalid &&
              ((state_q == DROP) || ((state_q == WAIT) && bus.redirect));
    issue   = !rst && (state_q == IDLE) && !bus.redirect &&
              ((count_q != DEPTH_C) || pop);
  end

  assign bus.mem_req   = issue;
  assign bus.mem_addr  = issue ? fetch_pc_q : addr_q;
  assign bus.ins_valid = !empty;
  assign bus.ins       = empty ? 32'h0 : word_q[rd_ptr_q];
  assign bus.ins_pc    = empty ? 32'h0 : pc_q[rd_ptr_q];
  assign state_o       = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else if (bus.redirect) begin
      fetch_pc_q <= bus.redirect_pc & ~32'h3;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      // Outstanding request with no response yet must be swallowed later.
      state_q    <= ((state_q != IDLE) && !bus.mem_rvalid) ? DROP : IDLE;
    end else begin
      if (push) wr_ptr_q <= inc_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= inc_ptr(rd_ptr_q);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
      case (state_q)
        IDLE: if (issue) begin
          addr_q     <= fetch_pc_q;
          fetch_pc_q <= fetch_pc_q + 32'd4;
          state_q    <= WAIT;
        end
        WAIT:    if (bus.mem_rvalid) state_q <= IDLE;
        DROP:    if (bus.mem_rvalid) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      word_q[wr_ptr_q] <= bus.mem_rdata;
      pc_q[wr_ptr_q]   <= addr_q;
    end
  end

`ifdef IFU_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= '0;
      drop_count  <= '0;
    end else begin
      if (push && (fetch_count != 16'hFFFF))   fetch_count <= fetch_count + 16'd1;
      if (discard && (drop_count != 16'hFFFF)) drop_count  <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-programmable memory model.
// Build with +define+IFU_STATS_EN to also check the statistics counters.
module tb_instr_fetch_unit;
  logic clk;
  logic rst;
  logic [1:0] state_o;
`ifdef IFU_STATS_EN
  logic [15:0] fetch_count;
  logic [15:0] drop_count;
`endif

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
`ifdef IFU_STATS_EN
    ,
    .fetch_count (fetch_count),
    .drop_count  (drop_count)
`endif
  );

  int vectors;
  int miscompares;

  // memory model state
  int          mem_lat;
  logic        pend;
  int          pcnt;
  logic [31:0] paddr;

  // outputs sampled at the falling edge
  logic        s_req;
  logic [31:0] s_addr;
  logic [31:0] s_ins;
  logic [31:0] s_pc;
  logic        s_valid;
  logic [1:0]  s_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h00b0_0533;
      32'h0000_0004: return 32'h0200_0513;
      32'h0000_0008: return 32'h0005_a503;
      32'h0000_000C: return 32'h00a5_a023;
      32'h0000_0010: return 32'h00b5_0263;
      32'h0000_0020: return 32'h00c5_8533;
      32'h0000_0040: return 32'h0400_006f;
      32'hFFFF_FFF8: return 32'hfedf_f0ef;
      32'hFFFF_FFFC: return 32'h0000_0013;
      default:       return 32'hdead_beef;
    endcase
  endfunction

  // One clock cycle: sample outputs mid-cycle, then update the memory response
  // just after the rising edge so it is stable for the whole next cycle.
  task automatic tick();
    @(negedge clk);
    s_req   = bus.mem_req;
    s_addr  = bus.mem_addr;
    s_ins   = bus.ins;
    s_pc    = bus.ins_pc;
    s_valid = bus.ins_valid;
    s_state = state_o;
    if (bus.mem_req === 1'b1) begin
      pend  = 1'b1;
      pcnt  = mem_lat;
      paddr = bus.mem_addr;
    end
    @(posedge clk);
    #1;
    bus.mem_rvalid = 1'b0;
    if (pend) begin
      pcnt = pcnt - 1;
      if (pcnt == 0) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = mem_word(paddr);
        pend = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.ins_ready = 1'b0;
    bus.mem_rvalid = 1'b0;
    pend = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    vectors++;
    if (s_req !== 1'b0 || s_addr !== 32'h0 || s_ins !== 32'h0 || s_pc !== 32'h0 ||
        s_valid !== 1'b0 || s_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_state: req=%b addr=%h ins=%h pc=%h valid=%b state=%0d, expected 0/0/0/0/0/0",
               s_req, s_addr, s_ins, s_pc, s_valid, s_state);
    end
`ifdef IFU_STATS_EN
    vectors++;
    if (fetch_count !== 16'd0 || drop_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_stats: fetch=%0d drop=%0d, expected 0/0", fetch_count, drop_count);
    end
`endif
  endtask

  task automatic test_fetch();
    do_reset();
    mem_lat = 1;
    bus.ins_ready = 1'b1;
    tick();
    vectors++;
    if (s_req !== 1'b1 || s_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL first_req: req=%b addr=%h, expected 1/00000000", s_req, s_addr);
    end
    tick();
    vectors++;
    if (s_valid !== 1'b0 || s_req !== 1'b0) begin
      miscompares++;
      $display("FAIL no_bypass: valid=%b req=%b, expected 0/0", s_valid, s_req);
    end
    tick();
    vectors++;
    if (s_valid !== 1'b1 || s_ins !== 32'h00b0_0533 || s_pc !== 32'h0 || s_req !== 1'b1 || s_addr !== 32'h4) begin
      miscompares++;
      $display("FAIL word0: valid=%b ins=%h pc=%h req=%b addr=%h, expected 1/00b00533/00000000/1/00000004",
               s_valid, s_ins, s_pc, s_req, s_addr);
    end
    tick();
    tick();
    vectors++;
    if (s_valid !== 1'b1 || s_ins !== 32'h0200_0513 || s_pc !== 32'h4 || s_req !== 1'b1 || s_addr !== 32'h8) begin
      miscompares++;
      $display("FAIL word1: valid=%b ins=%h pc=%h req=%b addr=%h, expected 1/02000513/00000004/1/00000008",
               s_valid, s_ins, s_pc, s_req, s_addr);
    end
  endtask

  // Continues from test_fetch: request to 8 is already outstanding.
  task automatic test_fill();
    bus.ins_ready = 1'b0;
    tick();
    tick();
    vectors++;
    if (s_ins !== 32'h0005_a503 || s_pc !== 32'h8 || s_req !== 1'b1 || s_addr !== 32'hC) begin
      miscompares++;
      $display("FAIL fill_word8: ins=%h pc=%h req=%b addr=%h, expected 0005a503/00000008/1/0000000c",
               s_ins, s_pc, s_req, s_addr);
    end
    tick();
    tick();
    vectors++;
    if (s_req !== 1'b0 || s_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL full_no_req: req=%b valid=%b, expected 0/1", s_req, s_valid);
    end
    tick();
    vectors++;
    if (s_req !== 1'b0 || s_addr !== 32'hC || s_ins !== 32'h0005_a503) begin
      miscompares++;
      $display("FAIL full_hold: req=%b addr=%h ins=%h, expected 0/0000000c/0005a503", s_req, s_addr, s_ins);
    end
    bus.ins_ready = 1'b1;
    tick();
    vectors++;
    if (s_req !== 1'b1 || s_addr !== 32'h10) begin
      miscompares++;
      $display("FAIL pop_frees_slot: req=%b addr=%h, expected 1/00000010", s_req, s_addr);
    end
    tick();
    vectors++;
    if (s_ins !== 32'h00a5_a023 || s_pc !== 32'hC) begin
      miscompares++;
      $display("FAIL fill_wordC: ins=%h pc=%h, expected 00a5a023/0000000c", s_ins, s_pc);
    end
    tick();
    vectors++;
    if (s_valid !== 1'b1 || s_ins !== 32'h00b5_0263 || s_pc !== 32'h10) begin
      miscompares++;
      $display("FAIL push_pop_same: valid=%b ins=%h pc=%h, expected 1/00b50263/00000010", s_valid, s_ins, s_pc);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    mem_lat = 3;
    bus.ins_ready = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h8;
    tick();
    vectors++;
    if (s_req !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_redirect_no_req: req=%b, expected 0", s_req);
    end
    bus.redirect = 1'b0;
    tick();
    vectors++;
    if (s_req !== 1'b1 || s_addr !== 32'h8) begin
      miscompares++;
      $display("FAIL redirect_target_req: req=%b addr=%h, expected 1/00000008", s_req, s_addr);
    end
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h40;
    tick();
    bus.redirect = 1'b0;
    tick();
    vectors++;
    if (s_state !== 2'd2 || s_req !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_to_drop: state=%0d req=%b, expected 2/0", s_state, s_req);
    end
    tick();
    tick();
    vectors++;
    if (s_req !== 1'b1 || s_addr !== 32'h40 || s_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL after_drop_req: req=%b addr=%h valid=%b, expected 1/00000040/0", s_req, s_addr, s_valid);
    end
`ifdef IFU_STATS_EN
    vectors++;
    if (drop_count !== 16'd1 || fetch_count !== 16'd0) begin
      miscompares++;
      $display("FAIL drop_stats: drop=%0d fetch=%0d, expected 1/0", drop_count, fetch_count);
    end
`endif
    tick();
    tick();
    tick();
    vectors++;
    if (s_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL dropped_not_pushed: valid=%b, expected 0", s_valid);
    end
    tick();
    vectors++;
    if (s_valid !== 1'b1 || s_ins !== 32'h0400_006f || s_pc !== 32'h40) begin
      miscompares++;
      $display("FAIL word40: valid=%b ins=%h pc=%h, expected 1/0400006f/00000040", s_valid, s_ins, s_pc);
    end
  endtask

  task automatic test_redirect_coincident();
    do_reset();
    mem_lat = 1;
    bus.ins_ready = 1'b0;
    tick();
    tick();
    tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h23;
    bus.ins_ready = 1'b1;
    tick();
    vectors++;
    if (s_valid !== 1'b1 || s_ins !== 32'h00b0_0533) begin
      miscompares++;
      $display("FAIL pre_flush_head: valid=%b ins=%h, expected 1/00b00533", s_valid, s_ins);
    end
    bus.redirect = 1'b0;
`ifdef IFU_STATS_EN
    vectors++;
    if (drop_count !== 16'd1 || fetch_count !== 16'd1) begin
      miscompares++;
      $display("FAIL coincident_stats: drop=%0d fetch=%0d, expected 1/1", drop_count, fetch_count);
    end
`endif
    tick();
    vectors++;
    if (s_valid !== 1'b0 || s_pc !== 32'h0 || s_req !== 1'b1 || s_addr !== 32'h20 || s_state !== 2'd0) begin
      miscompares++;
      $display("FAIL coincident_flush: valid=%b pc=%h req=%b addr=%h state=%0d, expected 0/00000000/1/00000020/0",
               s_valid, s_pc, s_req, s_addr, s_state);
    end
    tick();
    tick();
    vectors++;
    if (s_valid !== 1'b1 || s_ins !== 32'h00c5_8533 || s_pc !== 32'h20) begin
      miscompares++;
      $display("FAIL word20: valid=%b ins=%h pc=%h, expected 1/00c58533/00000020", s_valid, s_ins, s_pc);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    mem_lat = 1;
    bus.ins_ready = 1'b0;
    tick();
    tick();
    mem_lat = 3;
    tick();
    vectors++;
    if (s_valid !== 1'b1 || s_req !== 1'b1 || s_addr !== 32'h4) begin
      miscompares++;
      $display("FAIL pre_reset: valid=%b req=%b addr=%h, expected 1/1/00000004", s_valid, s_req, s_addr);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.ins_valid !== 1'b0 || bus.ins !== 32'h0 || bus.ins_pc !== 32'h0 || bus.mem_req !== 1'b0 ||
        bus.mem_addr !== 32'h0 || state_o !== 2'd0) begin
      miscompares++;
      $display("FAIL async_reset: valid=%b ins=%h pc=%h req=%b addr=%h state=%0d, expected 0/0/0/0/0/0",
               bus.ins_valid, bus.ins, bus.ins_pc, bus.mem_req, bus.mem_addr, state_o);
    end
`ifdef IFU_STATS_EN
    vectors++;
    if (fetch_count !== 16'd0) begin
      miscompares++;
      $display("FAIL async_reset_stats: fetch=%0d, expected 0", fetch_count);
    end
`endif
    tick();
    tick();
    tick();
    tick();
    vectors++;
    if (s_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL late_rvalid_in_reset: valid=%b, expected 0", s_valid);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (s_req !== 1'b1 || s_addr !== 32'h0 || s_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_req: req=%b addr=%h valid=%b, expected 1/00000000/0", s_req, s_addr, s_valid);
    end
    tick();
    tick();
    tick();
    tick();
    vectors++;
    if (s_valid !== 1'b1 || s_ins !== 32'h00b0_0533 || s_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL post_reset_word: valid=%b ins=%h pc=%h, expected 1/00b00533/00000000", s_valid, s_ins, s_pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    mem_lat = 1;
    bus.ins_ready = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    tick();
    bus.redirect = 1'b0;
    tick();
    vectors++;
    if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFF8) begin
      miscompares++;
      $display("FAIL wrap_addr0: req=%b addr=%h, expected 1/fffffff8", s_req, s_addr);
    end
    tick();
    tick();
    vectors++;
    if (s_ins !== 32'hfedf_f0ef || s_pc !== 32'hFFFF_FFF8 || s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap_addr1: ins=%h pc=%h req=%b addr=%h, expected fedff0ef/fffffff8/1/fffffffc",
               s_ins, s_pc, s_req, s_addr);
    end
    tick();
    tick();
    vectors++;
    if (s_ins !== 32'h0000_0013 || s_pc !== 32'hFFFF_FFFC || s_req !== 1'b1 || s_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_addr2: ins=%h pc=%h req=%b addr=%h, expected 00000013/fffffffc/1/00000000",
               s_ins, s_pc, s_req, s_addr);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    mem_lat = 1;
    pend = 1'b0;
    pcnt = 0;
    paddr = 32'h0;
    bus.mem_rdata = 32'h0;
    bus.mem_rvalid = 1'b0;
    bus.ins_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    test_reset();
    test_fetch();
    test_fill();
    test_redirect_wait();
    test_redirect_coincident();
    test_reset_mid_wait();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-side producer for the single-cycle processor: owns the fetch PC, reads words from instruction memory over a request/response handshake, and drives the `ins` word the processor decodes.
- Buffers fetched words in a small prefetch FIFO tagged with their PC.
- Accepts branch/jump redirects from the processor (BR / aluToPC path) and discards stale fetches.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- FIFO_DEPTH, 2, prefetch entries (word + PC); legal values 2..8.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- mem_req  output  1  one-cycle fetch request strobe.
- mem_addr  output  32  word-aligned fetch address, valid while mem_req=1.
- mem_rdata  input  32  returned instruction word.
- mem_rvalid  input  1  mem_rdata valid; one pulse per request, at least 1 cycle after mem_req.
- ins  output  32  FIFO head instruction; 32'h0 when FIFO empty.
- ins_pc  output  32  PC of FIFO head; 32'h0 when empty.
- ins_valid  output  1  FIFO non-empty.
- ins_ready  input  1  processor consumes head this cycle.
- redirect  input  1  taken branch/jump this cycle.
- redirect_pc  input  32  new fetch target; bits [1:0] ignored (forced 0).

Behaviour:
- Reset (async, immediate):
  - mem_req=0, mem_addr=RESET_PC, ins/ins_pc=0, ins_valid=0.
  - FIFO empty, fetch_pc=RESET_PC, state=IDLE.
- At most one outstanding request.
- FSM states:
  - IDLE: if no redirect and count<FIFO_DEPTH, pulse mem_req with mem_addr=fetch_pc, fetch_pc+=4, go to WAIT. A slot freed by a pop in the same cycle counts as available.
  - WAIT: on mem_rvalid, push {mem_rdata, request address} and go to IDLE. The next request can issue the following cycle, so back-to-back throughput is one word per (memory latency + 1) cycles.
  - DROP: on mem_rvalid, discard the data and go to IDLE.
- Redirect, any state:
  - FIFO flushed in the same edge; fetch_pc <= {redirect_pc[31:2],2'b00}.
  - If in WAIT with no mem_rvalid this cycle, go to DROP.
  - If mem_rvalid arrives in the same cycle, discard it and go to IDLE.
  - If in IDLE, no request that cycle; request to redirect_pc issues the next cycle.
  - If already in DROP, stay in DROP with the new target.
- Redirect with ins_ready in the same cycle: the pop is ignored and the flush wins.
- Redirect outranks any simultaneous push.
- Push and pop in the same cycle: count unchanged; order is preserved.
- Full FIFO: no request is issued.
- Empty FIFO: ins_ready is ignored.
- No same-cycle bypass: a word appears on ins the cycle after mem_rvalid.
- fetch_pc wraps 32'hFFFF_FFFC -> 0 silently.
- mem_addr holds its last value when mem_req=0.

Optional Feature:
- IFU_STATS_EN defined: adds ports fetch_count (output 16) and drop_count (output 16), both reset to 0.
  - fetch_count increments on every accepted push.
  - drop_count increments on every discarded response (DROP state, or redirect coincident with mem_rvalid).
  - Both saturate at 16'hFFFF.
- IFU_STATS_EN undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset release, 1-cycle-latency memory returning 32'h00b00533 @0 and 32'h02000513 @4, ins_ready=1:
  - mem_req with addr 0 the first cycle after rst falls.
  - ins=00b00533 with ins_pc=0, then ins=02000513 with ins_pc=4.
- ins_ready=0, memory returns 0005a503 / 00a5a023 / 00b50263 @8/C/10:
  - FIFO fills to 2, after which mem_req stays 0.
  - Raising ins_ready resumes fetching with mem_addr=10.
- Redirect to 32'h0000_0040 while WAIT on addr 8, response 3 cycles later:
  - Response dropped (drop_count=1 with IFU_STATS_EN).
  - Next mem_addr=40; ins_valid=0 until the word from 40 arrives.
- Redirect to 32'h0000_0023 coincident with mem_rvalid and ins_ready:
  - FIFO empty next cycle, the response is discarded, and the next mem_addr=20.
- Assert rst mid-WAIT with a pending response:
  - All outputs return to reset values immediately.
  - A late mem_rvalid during reset is ignored.
  - The first request after release goes to RESET_PC.
- Fetch starting at 32'hFFFF_FFF8 with jal word fedff0ef:
  - mem_addr sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
